// File: rtl/sharpen_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : sharpen_window_gen
// Brief    : Streaming 3x3 window generator (two line buffers plus a 3x3 shift
//            register) that feeds the sharpen kernel. Build option
//            SHARPEN_WIN_FLAGS_EN adds the win_sof_o/win_eol_o outputs.
// Revision : 1.0 - initial release
// ============================================================================
module sharpen_window_gen #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  in_pix_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [71:0] win_o,
  output logic        win_valid_o,
`ifdef SHARPEN_WIN_FLAGS_EN
  output logic        win_sof_o,
  output logic        win_eol_o,
`endif
  input  logic        win_ready_i
);

  localparam int C_COL_W = $clog2(IMG_WIDTH);
  localparam int C_ROW_W = $clog2(IMG_HEIGHT);

  logic [C_COL_W-1:0] col_q, col_d;
  logic [C_ROW_W-1:0] row_q, row_d;
  logic [7:0]         lb0_q [IMG_WIDTH];
  logic [7:0]         lb1_q [IMG_WIDTH];
  logic [7:0]         sr_q  [3][3];
  logic [7:0]         sr_d  [3][3];
  logic [71:0]        win_q, win_d;
  logic               win_valid_q, win_valid_d;
  logic               w_accept, w_done, w_last_col, w_last_row;

  assign in_ready_o  = !win_valid_q || win_ready_i;
  assign w_accept    = in_valid_i && in_ready_o;
  assign w_last_col  = (col_q == C_COL_W'(IMG_WIDTH - 1));
  assign w_last_row  = (row_q == C_ROW_W'(IMG_HEIGHT - 1));
  assign w_done      = w_accept && (row_q >= C_ROW_W'(2)) && (col_q >= C_COL_W'(2));
  assign win_o       = win_q;
  assign win_valid_o = win_valid_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (w_accept) begin
      if (w_last_col) begin
        col_d = '0;
        row_d = w_last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Next shift-register image; the emitted window is packed from it directly.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      sr_d[r][0] = sr_q[r][1];
      sr_d[r][1] = sr_q[r][2];
    end
    sr_d[0][2] = lb1_q[col_q];
    sr_d[1][2] = lb0_q[col_q];
    sr_d[2][2] = in_pix_i;
    win_d = '0;
    for (int k = 0; k < 9; k++) begin
      win_d[8*k +: 8] = sr_d[k/3][k%3];
    end
  end

  always_comb begin
    win_valid_d = win_valid_q;
    if (w_done) begin
      win_valid_d = 1'b1;
    end else if (win_valid_q && win_ready_i) begin
      win_valid_d = 1'b0;
    end
  end

  // Line memories and shift register are never cleared; stale data is masked by w_done.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && w_accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= in_pix_i;
      sr_q         <= sr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      if (w_done) begin
        win_q <= win_d;
      end
    end
  end

`ifdef SHARPEN_WIN_FLAGS_EN
  logic sof_q, eol_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sof_q <= 1'b0;
      eol_q <= 1'b0;
    end else if (w_done) begin
      sof_q <= (row_q == C_ROW_W'(2)) && (col_q == C_COL_W'(2));
      eol_q <= w_last_col;
    end
  end

  assign win_sof_o = sof_q;
  assign win_eol_o = eol_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sharpen_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sharpen_window_gen
// Brief    : Scoreboard bench: directed 4x4 instance plus random-stall 8x6 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sharpen_window_gen;

  typedef logic [73:0] exp_t;  // {sof, eol, window}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_iv, a_ir, a_wv, a_wr;
  logic [7:0]  a_pix;
  logic [71:0] a_win;
  logic        b_rst_n, b_iv, b_ir, b_wv, b_wr;
  logic [7:0]  b_pix;
  logic [71:0] b_win;
`ifdef SHARPEN_WIN_FLAGS_EN
  logic a_sof, a_eol, b_sof, b_eol;
`endif

  int   errors = 0;
  int   checks = 0;
  int   a_cnt  = 0;
  int   b_cnt  = 0;
  exp_t qa[$];
  exp_t qb[$];

  sharpen_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut_a (
    .clk_i(clk), .rst_n_i(a_rst_n), .in_pix_i(a_pix), .in_valid_i(a_iv),
    .in_ready_o(a_ir), .win_o(a_win), .win_valid_o(a_wv),
`ifdef SHARPEN_WIN_FLAGS_EN
    .win_sof_o(a_sof), .win_eol_o(a_eol),
`endif
    .win_ready_i(a_wr)
  );

  sharpen_window_gen #(.IMG_WIDTH(8), .IMG_HEIGHT(6)) u_dut_b (
    .clk_i(clk), .rst_n_i(b_rst_n), .in_pix_i(b_pix), .in_valid_i(b_iv),
    .in_ready_o(b_ir), .win_o(b_win), .win_valid_o(b_wv),
`ifdef SHARPEN_WIN_FLAGS_EN
    .win_sof_o(b_sof), .win_eol_o(b_eol),
`endif
    .win_ready_i(b_wr)
  );

  task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Window whose bottom-right pixel is (r,c) of frame f (row-major, width w).
  function automatic exp_t model(input logic [383:0] f, input int w, input int r, input int c);
    exp_t e;
    e = '0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++)
        e[8*(3*dy+dx) +: 8] = f[8*((r-2+dy)*w + (c-2+dx)) +: 8];
    e[73] = (r == 2) && (c == 2);
    e[72] = (c == w-1);
    return e;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    exp_t e;
    if (a_rst_n && a_wv && a_wr) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_window", a_win, '0);
      end else begin
        e = qa.pop_front();
        chk("a_win", a_win, e[71:0]);
`ifdef SHARPEN_WIN_FLAGS_EN
        chk("a_sof", a_sof, e[73]);
        chk("a_eol", a_eol, e[72]);
`endif
      end
      if (a_cnt == 0) chk("a_plan_first", a_win, 72'h222120121110020100);
      if (a_cnt == 3) chk("a_plan_last",  a_win, 72'h333231232221131211);
      if (a_cnt == 4) chk("a_plan_f2",    a_win, 72'h626160525150424140);
      a_cnt++;
    end
  end

  logic        b_prev_stall = 1'b0;
  logic [71:0] b_prev_win;
  always @(negedge clk) begin
    exp_t e;
    if (b_rst_n) begin
      chk("b_in_ready", b_ir, !b_wv || b_wr);
      if (b_prev_stall) begin
        chk("b_stall_valid", b_wv, 1'b1);
        chk("b_stall_win", b_win, b_prev_win);
      end
      if (b_wv && b_wr) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_window", b_win, '0);
        end else begin
          e = qb.pop_front();
          chk("b_win", b_win, e[71:0]);
`ifdef SHARPEN_WIN_FLAGS_EN
          chk("b_sof", b_sof, e[73]);
          chk("b_eol", b_eol, e[72]);
`endif
        end
        b_cnt++;
      end
      b_prev_stall = b_wv && !b_wr;
      b_prev_win   = b_win;
    end
  end

  // ---------------- drivers ----------------
  task automatic send_a(input logic [7:0] p, input logic do_push, input exp_t e);
    int n = 0;
    a_pix = p;
    a_iv  = 1'b1;
    if (do_push) qa.push_back(e);
    @(negedge clk);
    while (!a_ir && n < 500) begin n++; @(negedge clk); end
    if (!a_ir) chk("a_accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    a_iv = 1'b0;
  endtask

  task automatic frame_a(input logic [383:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      int r = i / 4;
      int c = i % 4;
      send_a(f[8*i +: 8], (r >= 2) && (c >= 2), model(f, 4, r, c));
    end
  endtask

  task automatic send_b(input logic [7:0] p, input logic do_push, input exp_t e);
    int n = 0;
    while ($urandom_range(0, 3) == 0) begin
      b_iv = 1'b0;
      @(posedge clk); #1;
    end
    b_pix = p;
    b_iv  = 1'b1;
    if (do_push) qb.push_back(e);
    @(negedge clk);
    while (!b_ir && n < 500) begin n++; @(negedge clk); end
    if (!b_ir) chk("b_accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    b_iv = 1'b0;
  endtask

  task automatic drain_a();
    int n = 0;
    while ((qa.size() != 0 || a_wv) && n < 100) begin @(posedge clk); #1; n++; end
    chk("a_drain_pending", qa.size(), 0);
  endtask

  task automatic run_a();
    logic [383:0] f1, f2, f3;
    f1 = '0; f2 = '0; f3 = '0;
    for (int i = 0; i < 16; i++) begin
      f1[8*i +: 8] = 8'(16*(i/4) + (i%4));
      f2[8*i +: 8] = f1[8*i +: 8] + 8'h40;
      f3[8*i +: 8] = 8'($urandom);
    end
    frame_a(f1, 0, 9);
    chk("a_no_early_valid", a_wv, 1'b0);
    frame_a(f1, 10, 10);
    chk("a_latency_valid", a_wv, 1'b1);
    chk("a_latency_win", a_win, 72'h222120121110020100);
    // Hold the consumer off with the next pixel pending.
    a_wr  = 1'b0;
    a_pix = f1[8*11 +: 8];
    a_iv  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("a_stall_in_ready", a_ir, 1'b0);
      chk("a_stall_valid", a_wv, 1'b1);
      chk("a_stall_win", a_win, 72'h222120121110020100);
    end
    @(posedge clk); #1;
    a_wr = 1'b1;
    frame_a(f1, 11, 15);
    frame_a(f2, 0, 15);
    drain_a();
    chk("a_count_two_frames", a_cnt, 8);
    // Mid-frame reset, then a fresh random frame.
    frame_a(f3, 0, 5);
    a_rst_n = 1'b0;
    @(posedge clk); #1;
    a_rst_n = 1'b1;
    chk("a_rst_valid", a_wv, 1'b0);
    chk("a_rst_in_ready", a_ir, 1'b1);
    chk("a_rst_win", a_win, '0);
    for (int i = 0; i < 16; i++) f3[8*i +: 8] = 8'($urandom);
    frame_a(f3, 0, 9);
    chk("a_restart_no_early", a_wv, 1'b0);
    frame_a(f3, 10, 10);
    chk("a_restart_valid", a_wv, 1'b1);
    frame_a(f3, 11, 15);
    drain_a();
    chk("a_count_total", a_cnt, 12);
  endtask

  task automatic run_b();
    logic [383:0] f;
    int n;
    for (int fr = 0; fr < 2; fr++) begin
      for (int i = 0; i < 48; i++) f[8*i +: 8] = 8'($urandom);
      for (int i = 0; i < 48; i++) begin
        int r = i / 8;
        int c = i % 8;
        send_b(f[8*i +: 8], (r >= 2) && (c >= 2), model(f, 8, r, c));
      end
    end
    n = 0;
    while ((qb.size() != 0 || b_wv) && n < 200) begin @(posedge clk); #1; n++; end
    chk("b_drain_pending", qb.size(), 0);
    chk("b_count", b_cnt, 48);
  endtask

  initial begin
    b_wr = 1'b1;
    forever begin
      @(posedge clk); #1;
      b_wr = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_iv = 1'b0; b_iv = 1'b0; a_wr = 1'b1;
    a_pix = '0; b_pix = '0;
    repeat (3) @(posedge clk);
    #1;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    chk("a_reset_valid", a_wv, 1'b0);
    chk("a_reset_win", a_win, '0);
    chk("a_reset_in_ready", a_ir, 1'b1);
    chk("b_reset_valid", b_wv, 1'b0);
`ifdef SHARPEN_WIN_FLAGS_EN
    chk("a_reset_flags", {a_sof, a_eol}, 2'b00);
`endif
    fork
      run_a();
      run_b();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
